// File: rtl/sb_pkg.sv
// Shared definitions for the sideband RX packet controller: FSM states,
// header field layout and counter widths.
package sb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DISCARD   = 2'd2,
        DELIVER   = 2'd3
    } state_e;

    localparam int SB_WIDTH        = 64;
    localparam int SB_NUM_DEST     = 4;
    localparam int SB_DEST_LSB     = 5;
    localparam int SB_DEST_W       = 2;
    localparam int SB_HAS_DATA_BIT = 4;
    localparam int SB_TIMEOUT      = 1024;
    localparam int SB_DROP_CNT_W   = 8;

endpackage

// File: rtl/sb_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sb_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sb_rx_packet_ctrl.sv
// Frames deserialized sideband words into header(+data) packets and hands each
// one to a single consumer; malformed or stalled packets are dropped and counted.
module sb_rx_packet_ctrl
    import sb_pkg::*;
#(
    parameter int WIDTH        = SB_WIDTH,
    parameter int NUM_DEST     = SB_NUM_DEST,
    parameter int DEST_LSB     = SB_DEST_LSB,
    parameter int DEST_W       = SB_DEST_W,
    parameter int HAS_DATA_BIT = SB_HAS_DATA_BIT,
    parameter int TIMEOUT      = SB_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         des_data,
    input  logic                     des_valid,
    output logic                     des_ready,
    output logic [NUM_DEST-1:0]      pkt_valid,
    input  logic [NUM_DEST-1:0]      pkt_ready,
    output logic [WIDTH-1:0]         pkt_hdr,
    output logic [WIDTH-1:0]         pkt_data,
    output logic                     pkt_has_data,
    output logic                     err_bad_dest,
    output logic                     err_timeout,
    output logic [SB_DROP_CNT_W-1:0] drop_count
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [DEST_W:0]   DEST_LIMIT = (DEST_W + 1)'(NUM_DEST);
    localparam logic [NUM_DEST-1:0] ONE_HOT0 = NUM_DEST'(1);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [WIDTH-1:0]    hdr_q, hdr_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                has_data_q, has_data_d;
    logic [NUM_DEST-1:0] valid_q, valid_d;
    logic                des_ready_q, des_ready_d;
    logic                err_bad_dest_q, err_bad_dest_d;
    logic                err_timeout_q, err_timeout_d;
    logic                drop_inc;
    logic                des_xfer;
    logic [DEST_W-1:0]   hdr_dest;
    logic                hdr_has_data;

    assign des_xfer     = des_valid & des_ready_q;
    assign hdr_dest     = des_data[DEST_LSB +: DEST_W];
    assign hdr_has_data = des_data[HAS_DATA_BIT];

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        dest_d         = dest_q;
        hdr_d          = hdr_q;
        data_d         = data_q;
        has_data_d     = has_data_q;
        valid_d        = valid_q;
        err_bad_dest_d = 1'b0;
        err_timeout_d  = 1'b0;
        drop_inc       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (des_xfer) begin
                    hdr_d      = des_data;
                    dest_d     = hdr_dest;
                    has_data_d = hdr_has_data;
                    data_d     = '0;
                    timer_d    = '0;
                    if ({1'b0, hdr_dest} >= DEST_LIMIT) begin
                        err_bad_dest_d = 1'b1;
                        drop_inc       = 1'b1;
                        if (hdr_has_data) begin
                            state_d = DISCARD;
                        end
                    end else if (hdr_has_data) begin
                        state_d = WAIT_DATA;
                    end else begin
                        valid_d = ONE_HOT0 << hdr_dest;
                        state_d = DELIVER;
                    end
                end
            end
            WAIT_DATA: begin
                if (des_xfer) begin
                    data_d  = des_data;
                    valid_d = ONE_HOT0 << dest_q;
                    state_d = DELIVER;
                end else if (timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    drop_inc      = 1'b1;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            // The packet was already counted as a bad-dest drop, so a stall here is silent.
            DISCARD: begin
                if (des_xfer || (timer_q == TIMER_LAST)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DELIVER: begin
                if (|(valid_q & pkt_ready)) begin
                    valid_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        des_ready_d = (state_d != DELIVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            dest_q         <= '0;
            hdr_q          <= '0;
            data_q         <= '0;
            has_data_q     <= 1'b0;
            valid_q        <= '0;
            des_ready_q    <= 1'b0;
            err_bad_dest_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            dest_q         <= dest_d;
            hdr_q          <= hdr_d;
            data_q         <= data_d;
            has_data_q     <= has_data_d;
            valid_q        <= valid_d;
            des_ready_q    <= des_ready_d;
            err_bad_dest_q <= err_bad_dest_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    sb_sat_counter #(
        .W(SB_DROP_CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (drop_inc),
        .count(drop_count)
    );

    assign des_ready    = des_ready_q;
    assign pkt_valid    = valid_q;
    assign pkt_hdr      = hdr_q;
    assign pkt_data     = data_q;
    assign pkt_has_data = has_data_q;
    assign err_bad_dest = err_bad_dest_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_sb_rx_packet_ctrl.sv
// Randomized packet traffic against a transaction-level model of the sideband
// RX controller, plus directed timeout, saturation and reset scenarios.
module tb_sb_rx_packet_ctrl;

    localparam int WIDTH        = 64;
    localparam int NUM_DEST     = 4;
    localparam int DEST_LSB     = 5;
    localparam int DEST_W       = 3;
    localparam int HAS_DATA_BIT = 4;
    localparam int TIMEOUT      = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    des_data;
    logic                des_valid;
    logic                des_ready;
    logic [NUM_DEST-1:0] pkt_valid;
    logic [NUM_DEST-1:0] pkt_ready;
    logic [WIDTH-1:0]    pkt_hdr;
    logic [WIDTH-1:0]    pkt_data;
    logic                pkt_has_data;
    logic                err_bad_dest;
    logic                err_timeout;
    logic [7:0]          drop_count;

    int n_checks   = 0;
    int n_fail     = 0;
    int model_drop = 0;

    sb_rx_packet_ctrl #(
        .WIDTH       (WIDTH),
        .NUM_DEST    (NUM_DEST),
        .DEST_LSB    (DEST_LSB),
        .DEST_W      (DEST_W),
        .HAS_DATA_BIT(HAS_DATA_BIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .des_data    (des_data),
        .des_valid   (des_valid),
        .des_ready   (des_ready),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_hdr     (pkt_hdr),
        .pkt_data    (pkt_data),
        .pkt_has_data(pkt_has_data),
        .err_bad_dest(err_bad_dest),
        .err_timeout (err_timeout),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_drop();
        model_drop = (model_drop < 255) ? model_drop + 1 : 255;
    endtask

    function automatic logic [63:0] make_hdr(input int dest, input bit has_data);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[DEST_LSB +: DEST_W] = dest[DEST_W-1:0];
        h[HAS_DATA_BIT]       = has_data;
        return h;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_des_ready"}, 64'(des_ready), 64'd0);
        check_output({tag, "_pkt_valid"}, 64'(pkt_valid), 64'd0);
        check_output({tag, "_pkt_hdr"}, pkt_hdr, 64'd0);
        check_output({tag, "_pkt_data"}, pkt_data, 64'd0);
        check_output({tag, "_has_data"}, 64'(pkt_has_data), 64'd0);
        check_output({tag, "_errs"}, 64'({err_bad_dest, err_timeout}), 64'd0);
        check_output({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    // Expects a packet on the bus, holds it off for 'stall' cycles, then accepts it.
    task automatic deliver_and_release(input logic [63:0] hdr, input logic [63:0] data,
                                       input bit has, input int dest, input int stall);
        logic [NUM_DEST-1:0] oh;
        logic [63:0]         exp_data;
        oh       = '0;
        oh[dest] = 1'b1;
        exp_data = has ? data : 64'd0;
        check_output("dlv_valid", 64'(pkt_valid), 64'(oh));
        check_output("dlv_hdr", pkt_hdr, hdr);
        check_output("dlv_data", pkt_data, exp_data);
        check_output("dlv_has_data", 64'(pkt_has_data), 64'(has));
        check_output("dlv_des_ready", 64'(des_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            pkt_ready = NUM_DEST'($urandom) & ~oh;
            des_valid = 1'($urandom_range(0, 1));
            des_data  = {$urandom, $urandom};
            tick();
            check_output("stall_valid", 64'(pkt_valid), 64'(oh));
            check_output("stall_hdr_data", 64'((pkt_hdr == hdr) && (pkt_data == exp_data)), 64'd1);
            check_output("stall_des_ready", 64'(des_ready), 64'd0);
        end
        des_valid = 1'b0;
        pkt_ready = oh | (NUM_DEST'($urandom) & ~oh);
        tick();
        pkt_ready = '0;
        check_output("release_valid", 64'(pkt_valid), 64'd0);
        check_output("release_des_ready", 64'(des_ready), 64'd1);
    endtask

    task automatic send_packet(input logic [63:0] hdr, input logic [63:0] data,
                               input int gap, input int stall);
        int dest;
        bit has;
        dest = int'(hdr[DEST_LSB +: DEST_W]);
        has  = hdr[HAS_DATA_BIT];
        check_output("hdr_des_ready", 64'(des_ready), 64'd1);
        des_valid = 1'b1;
        des_data  = hdr;
        tick();
        des_valid = 1'b0;
        if (dest >= NUM_DEST) begin
            note_drop();
            check_output("bad_dest_pulse", 64'(err_bad_dest), 64'd1);
            check_output("bad_dest_no_timeout", 64'(err_timeout), 64'd0);
            check_output("bad_dest_drop_count", 64'(drop_count), 64'(model_drop));
            check_output("bad_dest_no_valid", 64'(pkt_valid), 64'd0);
            if (has) begin
                repeat (gap) tick();
                des_valid = 1'b1;
                des_data  = data;
                tick();
                des_valid = 1'b0;
                check_output("discard_no_pulse", 64'(err_bad_dest), 64'd0);
                check_output("discard_no_valid", 64'(pkt_valid), 64'd0);
                check_output("discard_ready", 64'(des_ready), 64'd1);
                check_output("discard_drop_count", 64'(drop_count), 64'(model_drop));
            end
        end else begin
            check_output("good_no_err", 64'(err_bad_dest), 64'd0);
            if (has) begin
                check_output("wait_no_valid", 64'(pkt_valid), 64'd0);
                check_output("wait_ready", 64'(des_ready), 64'd1);
                repeat (gap) tick();
                des_valid = 1'b1;
                des_data  = data;
                tick();
                des_valid = 1'b0;
            end
            deliver_and_release(hdr, data, has, dest, stall);
        end
    endtask

    initial begin
        logic [63:0] hdr;
        logic [63:0] data;
        int          seen;

        rst       = 1'b1;
        des_valid = 1'b0;
        des_data  = '0;
        pkt_ready = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_output("post_reset_ready", 64'(des_ready), 64'd1);

        $display("[TB] directed: header-only, data with stall, bad destination");
        send_packet(64'h20, 64'h0, 0, 0);
        send_packet(64'h50, 64'hDEAD_BEEF, 0, 5);
        send_packet(64'h90, {$urandom, $urandom}, 2, 0);
        check_output("bad_dest_count_one", 64'(drop_count), 64'd1);

        $display("[TB] directed: data word timeout");
        hdr = make_hdr(2, 1'b1);
        des_valid = 1'b1;
        des_data  = hdr;
        tick();
        des_valid = 1'b0;
        seen = 0;
        for (int i = 1; i <= TIMEOUT + 50 && seen == 0; i++) begin
            tick();
            if (err_timeout) seen = i;
        end
        check_output("timeout_cycle", 64'(seen), 64'(TIMEOUT));
        note_drop();
        check_output("timeout_drop_count", 64'(drop_count), 64'(model_drop));
        check_output("timeout_no_bad_dest", 64'(err_bad_dest), 64'd0);
        check_output("timeout_idle_ready", 64'(des_ready), 64'd1);
        tick();
        check_output("timeout_single_pulse", 64'(err_timeout), 64'd0);
        send_packet(make_hdr(0, 1'b0), 64'h0, 0, 1);

        $display("[TB] directed: data arrives on the last cycle before timeout");
        hdr  = make_hdr(3, 1'b1);
        data = {$urandom, $urandom};
        des_valid = 1'b1;
        des_data  = hdr;
        tick();
        des_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check_output("late_data_no_timeout", 64'(err_timeout), 64'd0);
        des_valid = 1'b1;
        des_data  = data;
        tick();
        des_valid = 1'b0;
        check_output("late_data_no_timeout2", 64'(err_timeout), 64'd0);
        deliver_and_release(hdr, data, 1'b1, 3, 2);

        $display("[TB] randomized packet traffic");
        for (int p = 0; p < 60; p++) begin
            hdr  = make_hdr(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            data = {$urandom, $urandom};
            send_packet(hdr, data, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        end

        $display("[TB] directed: drop counter saturation");
        des_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            des_data = make_hdr(int'($urandom_range(4, 7)), 1'b0);
            tick();
            note_drop();
        end
        des_valid = 1'b0;
        check_output("sat_drop_count", 64'(drop_count), 64'(model_drop));
        check_output("sat_at_255", 64'(drop_count), 64'd255);
        check_output("sat_last_pulse", 64'(err_bad_dest), 64'd1);
        tick();
        check_output("sat_pulse_clears", 64'(err_bad_dest), 64'd0);
        check_output("sat_holds", 64'(drop_count), 64'd255);

        $display("[TB] directed: reset in WAIT_DATA and DELIVER");
        des_valid = 1'b1;
        des_data  = make_hdr(3, 1'b1);
        tick();
        des_valid = 1'b0;
        check_output("rst_wait_no_valid", 64'(pkt_valid), 64'd0);
        #2 rst = 1'b1;
        #1;
        model_drop = 0;
        check_reset_outputs("rst_wait");
        tick();
        rst = 1'b0;
        tick();
        check_output("rst_wait_resume_ready", 64'(des_ready), 64'd1);
        check_output("rst_wait_no_err", 64'({err_bad_dest, err_timeout}), 64'd0);

        des_valid = 1'b1;
        des_data  = make_hdr(1, 1'b0);
        tick();
        des_valid = 1'b0;
        check_output("rst_dlv_valid", 64'(pkt_valid), 64'b0010);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_dlv");
        tick();
        rst = 1'b0;
        tick();
        check_output("rst_dlv_resume_ready", 64'(des_ready), 64'd1);
        check_output("rst_dlv_no_err", 64'({err_bad_dest, err_timeout}), 64'd0);
        send_packet(make_hdr(2, 1'b1), {$urandom, $urandom}, 1, 1);
        send_packet(make_hdr(5, 1'b0), 64'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
